// File: rtl/compare_pkg.sv
// rtl/compare_pkg.sv - shared FSM state and result encodings for compare_serial

package compare_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // One-hot {lt, eq, gt} result codes; CMP_NONE is the state before the first done
  localparam logic [2:0] CMP_NONE = 3'b000;
  localparam logic [2:0] CMP_LT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_GT   = 3'b001;

endpackage

// File: rtl/compare_digit.sv
// rtl/compare_digit.sv - combinational magnitude compare of one DIGIT-bit slice

module compare_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  // Unsigned ordering of the two digit slices
  always_comb begin
    lt = (a < b);
    eq = (a == b);
    gt = (a > b);
  end

endmodule

// File: rtl/compare_serial.sv
// rtl/compare_serial.sv - MSB-first serial magnitude comparator, optional signed mode via COMPARE_SIGNED_EN

import compare_pkg::*;

module compare_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMPARE_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG) + 1;

`ifdef COMPARE_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       res_q, res_d;
  logic             done_q, done_d;

  logic dig_lt, dig_eq, dig_gt;
  logic last_dig;

  compare_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (sa_q[WIDTH-1 -: DIGIT]),
    .b  (sb_q[WIDTH-1 -: DIGIT]),
    .lt (dig_lt),
    .eq (dig_eq),
    .gt (dig_gt)
  );

  assign last_dig = (cnt_q == CW'(NDIG - 1));

  // Next-state: load operands on start, then walk digits until a difference or the last one
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d = a;
          sb_d = b;
`ifdef COMPARE_SIGNED_EN
          if (is_signed) begin
            sa_d = a ^ MSB_MASK;
            sb_d = b ^ MSB_MASK;
          end
`endif
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sa_d  = sa_q << DIGIT;
        sb_d  = sb_q << DIGIT;
        cnt_d = cnt_q + CW'(1);
        if (!dig_eq || last_dig) begin
          if (dig_lt)      res_d = CMP_LT;
          else if (dig_gt) res_d = CMP_GT;
          else             res_d = CMP_EQ;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any comparison without a done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      res_q   <= CMP_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy         = (state_q == S_RUN);
  assign done         = done_q;
  assign {lt, eq, gt} = res_q;

endmodule

// File: tb/tb_compare_serial.sv
// tb/tb_compare_serial.sv - directed self-checking bench for compare_serial

module tb_compare_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
`ifdef COMPARE_SIGNED_EN
  logic        is_signed;
`endif
  logic        busy, done, lt, eq, gt;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] cyc = 0;
  logic [31:0] start_cyc = 0;
  int          lat;
  int          busy_n;
  logic        seen_done;

  compare_serial #(.WIDTH(16), .DIGIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef COMPARE_SIGNED_EN
    .is_signed (is_signed),
`endif
    .busy      (busy),
    .done      (done),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents start for one edge and returns at the following negedge
  task automatic do_start(input logic [15:0] va, input logic [15:0] vb);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(negedge clk);
    start     = 1'b0;
    a         = 16'hDEAD;
    b         = 16'hBEEF;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    logic got;
    got    = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (busy) busy_n++;
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    lat = int'(cyc - start_cyc);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef COMPARE_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", {29'd0, lt, eq, gt}, 32'b000);

    // first digit differs
    do_start(16'h8000, 16'h7FFF);
    chk("first_busy", {31'd0, busy}, 32'd1);
    wait_done("first");
    chk("first_res", {29'd0, lt, eq, gt}, 32'b001);
    chk("first_lat", lat, 32'd1);
    chk("first_busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("first_done_pulse", {31'd0, done}, 32'd0);

    // equal operands run every digit
    do_start(16'h1234, 16'h1234);
    wait_done("equal");
    chk("equal_res", {29'd0, lt, eq, gt}, 32'b010);
    chk("equal_lat", lat, 32'd8);
    chk("equal_busy_cycles", busy_n, 32'd8);
    @(negedge clk);

    // last digit differs; previous result held while busy
    do_start(16'h0001, 16'h0002);
    chk("hold_eq", {29'd0, lt, eq, gt}, 32'b010);
    wait_done("last");
    chk("last_res", {29'd0, lt, eq, gt}, 32'b100);
    chk("last_lat", lat, 32'd8);
    @(negedge clk);

    // middle digit differs
    do_start(16'h0400, 16'h0000);
    wait_done("mid");
    chk("mid_res", {29'd0, lt, eq, gt}, 32'b001);
    chk("mid_lat", lat, 32'd3);
    @(negedge clk);

    // start while busy is ignored
    do_start(16'h1234, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored");
    chk("ignored_res", {29'd0, lt, eq, gt}, 32'b010);
    chk("ignored_lat", lat, 32'd8);

    // start in the done cycle is accepted
    do_start(16'h0000, 16'h0001);
    wait_done("b2b");
    chk("b2b_res", {29'd0, lt, eq, gt}, 32'b100);
    chk("b2b_lat", lat, 32'd8);
    @(negedge clk);

    // reset mid-run
    do_start(16'h1234, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_res", {29'd0, lt, eq, gt}, 32'b000);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen_done}, 32'd0);
    do_start(16'h0005, 16'h0003);
    wait_done("after_rst");
    chk("after_rst_res", {29'd0, lt, eq, gt}, 32'b001);
    chk("after_rst_lat", lat, 32'd7);
    @(negedge clk);

`ifdef COMPARE_SIGNED_EN
    is_signed = 1'b1;
    do_start(16'hFFFF, 16'h0001);
    is_signed = 1'b0;
    wait_done("signed");
    chk("signed_res", {29'd0, lt, eq, gt}, 32'b100);
    chk("signed_lat", lat, 32'd1);
    @(negedge clk);
    is_signed = 1'b0;
    do_start(16'hFFFF, 16'h0001);
    wait_done("unsigned");
    chk("unsigned_res", {29'd0, lt, eq, gt}, 32'b001);
    chk("unsigned_lat", lat, 32'd1);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
